// File: rtl/wb_gpio_pkg.sv
// Shared register map, bus FSM state type and byte-lane helpers for the
// Wishbone GPIO block.
package wb_gpio_pkg;

    // Word indices (byte address bits [4:2])
    localparam logic [2:0] REG_IN      = 3'd0;
    localparam logic [2:0] REG_OUT     = 3'd1;
    localparam logic [2:0] REG_DIR     = 3'd2;
    localparam logic [2:0] REG_SET     = 3'd3;
    localparam logic [2:0] REG_CLR     = 3'd4;
    localparam logic [2:0] REG_RISE_EN = 3'd5;
    localparam logic [2:0] REG_FALL_EN = 3'd6;
    localparam logic [2:0] REG_STATUS  = 3'd7;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_t;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Take new_val on selected byte lanes, keep old_val on the others.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = byte_mask(sel);
        return (new_val & m) | (old_val & ~m);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser with edge detection. Edges are masked until the
// chain and prev flops hold real pad samples after reset.
module gpio_sync_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  prev;
    logic [CNT_W-1:0]                  warm_cnt;
    logic                              warm_done;

    // Shift pads through the chain, remember last synchronised value, count down warm-up
    always_ff @(posedge clk) begin
        if (rst) begin
            chain    <= '0;
            prev     <= '0;
            warm_cnt <= WARM_INIT;
        end else begin
            // NOTE: non-blocking so each stage samples its neighbour's pre-edge value;
            // blocking assignments would collapse the chain into a single flop.
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= s;
            if (warm_cnt != '0) begin
                warm_cnt <= warm_cnt - CNT_W'(1);
            end
        end
    end

    assign s         = chain[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == '0);
    assign rise      = warm_done ? (s & ~prev) : '0;
    assign fall      = warm_done ? (~s & prev) : '0;

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO slave: direction, atomic set/clear, edge capture
// into a write-1-to-clear status register and a level interrupt.
module wb_gpio_irq
    import wb_gpio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [2:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    // Byte-lane merge narrowed to the pin width; bits above WIDTH are dropped.
    function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] cur,
                                                 input logic [31:0]      nxt,
                                                 input logic [3:0]       sel);
        return WIDTH'(byte_merge(32'(cur), nxt, sel));
    endfunction

    logic [WIDTH-1:0] pin_s, pin_rise, pin_fall;
    logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q;
    logic [WIDTH-1:0] wr_bits, edge_hit, status_clr;
    logic [31:0]      rd_data;
    logic             irq_q;
    logic             access, wr_en;
    bus_state_t       state;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .pin  (gpio_i),
        .s    (pin_s),
        .rise (pin_rise),
        .fall (pin_fall)
    );

    // A new access is only taken while idle, so a held strobe acks every other cycle.
    assign access   = (state == BUS_IDLE) && wb_cyc_i && wb_stb_i;
    assign wr_en    = access && wb_we_i;
    assign wr_bits  = merge_w('0, wb_dat_i, wb_sel_i);
    assign edge_hit = (pin_rise & rise_en_q) | (pin_fall & fall_en_q);

    // Read mux and write-1-to-clear mask for the current access
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        rd_data    = '0;
        status_clr = '0;
        case (wb_adr_i)
            REG_IN:                    rd_data = 32'(pin_s);
            REG_OUT, REG_SET, REG_CLR: rd_data = 32'(out_q);
            REG_DIR:                   rd_data = 32'(dir_q);
            REG_RISE_EN:               rd_data = 32'(rise_en_q);
            REG_FALL_EN:               rd_data = 32'(fall_en_q);
            REG_STATUS:                rd_data = 32'(status_q);
            default:                   rd_data = '0;
        endcase
        if (wr_en && (wb_adr_i == REG_STATUS)) begin
            status_clr = wr_bits;
        end
    end

    // Bus FSM with registered ack/read data and the control register writes
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= BUS_IDLE;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            out_q     <= OUT_RESET;
            dir_q     <= DIR_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else begin
            case (state)
                BUS_IDLE: begin
                    if (access) begin
                        state    <= BUS_ACK;
                        wb_ack_o <= 1'b1;
                        wb_dat_o <= rd_data;
                        if (wb_we_i) begin
                            case (wb_adr_i)
                                REG_OUT:     out_q     <= merge_w(out_q, wb_dat_i, wb_sel_i);
                                REG_DIR:     dir_q     <= merge_w(dir_q, wb_dat_i, wb_sel_i);
                                REG_SET:     out_q     <= out_q | wr_bits;
                                REG_CLR:     out_q     <= out_q & ~wr_bits;
                                REG_RISE_EN: rise_en_q <= merge_w(rise_en_q, wb_dat_i, wb_sel_i);
                                REG_FALL_EN: fall_en_q <= merge_w(fall_en_q, wb_dat_i, wb_sel_i);
                                default:     ;  // IN is read-only, STATUS handled below
                            endcase
                        end
                    end
                end
                BUS_ACK: begin
                    state    <= BUS_IDLE;
                    wb_ack_o <= 1'b0;
                end
                default: begin
                    state    <= BUS_IDLE;
                    wb_ack_o <= 1'b0;
                end
            endcase
        end
    end

    // Edge capture into STATUS (a new edge beats a same-cycle clear) and registered irq
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= edge_hit | (status_q & ~status_clr);
            irq_q    <= |status_q;
        end
    end

    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = irq_q;

endmodule

// File: tb/tb_wb_gpio_irq.sv
// Scoreboard bench for wb_gpio_irq: bus tasks queue the expected response,
// a monitor pops and compares on every ack.
module tb_wb_gpio_irq;
    import wb_gpio_pkg::*;

    localparam int WIDTH = 8;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i;
    logic [2:0]       wb_adr_i;
    logic [31:0]      wb_dat_i;
    logic [31:0]      wb_dat_o;
    logic [3:0]       wb_sel_i;
    logic             wb_we_i;
    logic             wb_cyc_i;
    logic             wb_stb_i;
    logic             wb_ack_o;
    logic [WIDTH-1:0] gpio_i;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] gpio_dir_o;
    logic             irq_o;

    typedef struct {
        bit          is_read;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_gpio_irq #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .OUT_RESET   (8'hA5),
        .DIR_RESET   (8'h0F)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_ack_o   (wb_ack_o),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every ack must match the oldest queued access; reads compare data.
    always @(negedge wb_clk_i) begin
        if (wb_ack_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with no access pending, expected none");
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.is_read) check(mon_e.name, wb_dat_o, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // Issue one access and return in the cycle where ack is visible.
    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [31:0] exp_rd, input string name);
        exp_t e;
        int   n;
        e.is_read = !we;
        e.data    = exp_rd;
        e.name    = name;
        sb_q.push_back(e);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        tick();
        n = 1;
        while (wb_ack_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (wb_ack_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no ack within %0d cycles, expected ack", name, n);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // Full access plus the following cycle, where ack must have dropped.
    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input string name);
        bus(1'b1, adr, dat, sel, 32'h0, name);
        tick();
        check({name, "_ack_drop"}, {31'b0, wb_ack_o}, 32'h0);
    endtask

    task automatic rd(input logic [2:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, 4'hF, exp, name);
        tick();
        check({name, "_ack_drop"}, {31'b0, wb_ack_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        wb_rst_i = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        gpio_i   = 8'h3C;          // bit 3 high through reset and warm-up

        // Reset values
        repeat (3) tick();
        check("rst_gpio_o",   32'(gpio_o),     32'hA5);
        check("rst_dir",      32'(gpio_dir_o), 32'h0F);
        check("rst_irq",      {31'b0, irq_o},  32'h0);
        check("rst_ack",      {31'b0, wb_ack_o}, 32'h0);
        check("rst_dat_o",    wb_dat_o,        32'h0);
        wb_rst_i = 1'b0;
        repeat (6) tick();
        rd(REG_STATUS, 32'h0,        "warmup_status");
        rd(REG_IN,     32'h0000003C, "in_read");

        // OUT / SET / CLR and byte-select masking
        wr(REG_OUT, 32'h0000_0000, 4'hF, "out_zero");
        check("out_zero_val", 32'(gpio_o), 32'h00);
        wr(REG_SET, 32'h0000_0081, 4'hF, "set_81");
        check("set_81_val", 32'(gpio_o), 32'h81);
        wr(REG_CLR, 32'h0000_0001, 4'hF, "clr_01");
        check("clr_01_val", 32'(gpio_o), 32'h80);
        wr(REG_OUT, 32'hFFFF_FF12, 4'b0001, "out_sel0");
        check("out_sel0_val", 32'(gpio_o), 32'h12);
        rd(REG_OUT, 32'h0000_0012, "out_readback");
        wr(REG_SET, 32'h0000_00FF, 4'b0010, "set_unsel");
        rd(REG_SET, 32'h0000_0012, "set_unsel_rb");
        wr(REG_DIR, 32'hFFFF_FF55, 4'b0000, "dir_nosel");
        rd(REG_DIR, 32'h0000_000F, "dir_nosel_rb");
        wr(REG_IN,  32'h0000_00FF, 4'hF, "in_write");
        rd(REG_IN,  32'h0000_003C, "in_write_rb");

        // Rising edge capture and latency
        gpio_i = 8'h34;
        wr(REG_RISE_EN, 32'h0000_0008, 4'hF, "rise_en");
        repeat (4) tick();
        rd(REG_STATUS, 32'h0, "fall_not_enabled");
        gpio_i = 8'h3C;
        tick();
        tick();
        bus(1'b0, REG_STATUS, 32'h0, 4'hF, 32'h0, "status_before_lat");
        check("irq_at_lat3", {31'b0, irq_o}, 32'h0);
        tick();
        check("irq_at_lat4", {31'b0, irq_o}, 32'h1);
        rd(REG_STATUS, 32'h0000_0008, "rise_status");

        // W1C honours byte select; clear drops irq one cycle later
        wr(REG_STATUS, 32'h0000_0008, 4'b0000, "w1c_nosel");
        rd(REG_STATUS, 32'h0000_0008, "w1c_nosel_rb");
        wr(REG_STATUS, 32'h0000_0008, 4'b0001, "w1c_rise");
        check("w1c_rise_irq", {31'b0, irq_o}, 32'h0);
        rd(REG_STATUS, 32'h0, "w1c_rise_rb");

        // Falling edge capture
        wr(REG_RISE_EN, 32'h0, 4'hF, "rise_dis");
        wr(REG_FALL_EN, 32'h0000_0008, 4'hF, "fall_en");
        gpio_i = 8'h34;
        repeat (5) tick();
        rd(REG_STATUS, 32'h0000_0008, "fall_status");
        check("fall_irq", {31'b0, irq_o}, 32'h1);
        wr(REG_STATUS, 32'h0000_0008, 4'hF, "w1c_fall");
        check("w1c_fall_irq", {31'b0, irq_o}, 32'h0);
        rd(REG_STATUS, 32'h0, "w1c_fall_rb");

        // Falling edge in the same cycle as the W1C: set wins
        gpio_i = 8'h3C;
        repeat (5) tick();
        rd(REG_STATUS, 32'h0, "rise_ignored");
        gpio_i = 8'h34;
        tick();
        tick();
        wr(REG_STATUS, 32'h0000_0008, 4'hF, "w1c_collide");
        rd(REG_STATUS, 32'h0000_0008, "set_wins");

        // Disabling the enable keeps captured status
        wr(REG_FALL_EN, 32'h0, 4'hF, "fall_dis");
        rd(REG_STATUS, 32'h0000_0008, "status_kept");

        // Back-to-back writes with strobe held: ack 0,1,0,1
        wr(REG_OUT, 32'h0000_0080, 4'hF, "b2b_init");
        sb_q.push_back('{1'b0, 32'h0, "b2b_w1"});
        sb_q.push_back('{1'b0, 32'h0, "b2b_w2"});
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_sel_i = 4'hF;
        wb_adr_i = REG_SET;
        wb_dat_i = 32'h0000_0001;
        check("b2b_ack0", {31'b0, wb_ack_o}, 32'h0);
        tick();
        check("b2b_ack1", {31'b0, wb_ack_o}, 32'h1);
        check("b2b_set",  32'(gpio_o), 32'h81);
        wb_adr_i = REG_CLR;
        wb_dat_i = 32'h0000_0080;
        tick();
        check("b2b_ack2", {31'b0, wb_ack_o}, 32'h0);
        check("b2b_hold", 32'(gpio_o), 32'h81);
        tick();
        check("b2b_ack3", {31'b0, wb_ack_o}, 32'h1);
        check("b2b_clr",  32'(gpio_o), 32'h01);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        tick();
        check("b2b_ack4", {31'b0, wb_ack_o}, 32'h0);
        check("b2b_final", 32'(gpio_o), 32'h01);

        // Reset during a CLR strobe: no ack, no side effect, all back to reset
        wr(REG_OUT, 32'h0000_00FF, 4'hF, "pre_rst_out");
        wb_rst_i = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = REG_CLR;
        wb_dat_i = 32'h0000_00FF;
        tick();
        check("midrst_ack",    {31'b0, wb_ack_o}, 32'h0);
        check("midrst_gpio_o", 32'(gpio_o), 32'hA5);
        check("midrst_dir",    32'(gpio_dir_o), 32'h0F);
        check("midrst_irq",    {31'b0, irq_o}, 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_rst_i = 1'b0;
        repeat (5) tick();
        rd(REG_STATUS,  32'h0,  "post_rst_status");
        rd(REG_OUT,     32'hA5, "post_rst_out");
        rd(REG_FALL_EN, 32'h0,  "post_rst_fall_en");

        repeat (3) tick();
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
